// File: rtl/processor_operand_fetch_pkg.sv
// Shared definitions for the asm18 core's operand-fetch stage.
// Contents:
//   OP_*        4-bit opcode constants (the top nibble of the instruction word)
//   state_t     RUN/WAIT state of the operand-fetch FSM
//   source_use  returns which source registers an opcode reads, as {uses_rx, uses_ry}
package processor_pkg;

  localparam logic [3:0] OP_ADD               = 4'h0;
  localparam logic [3:0] OP_SUB               = 4'h1;
  localparam logic [3:0] OP_AND               = 4'h2;
  localparam logic [3:0] OP_OR                = 4'h3;
  localparam logic [3:0] OP_XOR               = 4'h4;
  localparam logic [3:0] OP_SHIFT             = 4'h5;
  localparam logic [3:0] OP_READ_FROM_MEMORY  = 4'h6;
  localparam logic [3:0] OP_WRITE_TO_MEMORY   = 4'h7;
  localparam logic [3:0] OP_IF                = 4'h8;
  localparam logic [3:0] OP_CALL_IMM14        = 4'h9;
  localparam logic [3:0] OP_JUMP              = 4'hA;
  localparam logic [3:0] OP_WAIT              = 4'hB;
  localparam logic [3:0] OP_LOAD_IMM          = 4'hC;
  localparam logic [3:0] OP_NOP               = 4'hF;

  typedef enum logic {
    RUN  = 1'b0,
    WAIT = 1'b1
  } state_t;

  // {uses_rx, uses_ry}. CALL reports ry as used because its second read
  // port is redirected to the stack pointer.
  function automatic logic [1:0] source_use(input logic [3:0] op);
    case (op)
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_SHIFT,
      OP_WRITE_TO_MEMORY:               source_use = 2'b11;
      OP_READ_FROM_MEMORY, OP_JUMP,
      OP_CALL_IMM14:                    source_use = 2'b01;
      OP_IF:                            source_use = 2'b10;
      default:                          source_use = 2'b00;
    endcase
  endfunction

endpackage

// File: rtl/processor_operand_fetch_if.sv
// Pipeline bus of the operand-fetch stage: the fetch-side input handshake with
// its payload (ip, ip_plus_one, code_word) and the execute-side output handshake
// with its registered payload.
//   master: the surroundings (fetch and execute stages)
//   slave:  the operand-fetch stage itself
interface processor_operand_fetch_if #(
  parameter int ADDR_SIZE = 18,
  parameter int WORD_SIZE = 18
);
  logic                 in_valid;
  logic                 in_ready;
  logic [ADDR_SIZE-1:0] ip;
  logic [ADDR_SIZE-1:0] ip_plus_one;
  logic [WORD_SIZE-1:0] code_word;

  logic                 out_valid;
  logic                 out_ready;
  logic [WORD_SIZE-1:0] alu_data0_out;
  logic [WORD_SIZE-1:0] alu_data1_out;
  logic [WORD_SIZE-1:0] code_word_out;
  logic [ADDR_SIZE-1:0] ip_out;
  logic [ADDR_SIZE-1:0] ip_plus_one_out;
  logic [ADDR_SIZE-1:0] data1_plus_imm_out;

  modport master (
    output in_valid, ip, ip_plus_one, code_word, out_ready,
    input  in_ready, out_valid, alu_data0_out, alu_data1_out, code_word_out,
           ip_out, ip_plus_one_out, data1_plus_imm_out
  );

  modport slave (
    input  in_valid, ip, ip_plus_one, code_word, out_ready,
    output in_ready, out_valid, alu_data0_out, alu_data1_out, code_word_out,
           ip_out, ip_plus_one_out, data1_plus_imm_out
  );
endinterface

// File: rtl/processor_operand_fetch_operand_forward.sv
// Bypass mux for one source operand.
//   read_addr      register index being read
//   rf_data        asynchronous register-file data for read_addr
//   ex_*           execute-stage result; ignored when it is a load (value not ready)
//   wb_*           writeback port
//   data           selected operand: EX, else WB, else register file
module operand_forward
  import processor_pkg::*;
#(
  parameter int REG_BITS  = 3,
  parameter int WORD_SIZE = 18
) (
  input  logic [REG_BITS-1:0]  read_addr,
  input  logic [WORD_SIZE-1:0] rf_data,
  input  logic                 ex_write_enable,
  input  logic                 ex_is_load,
  input  logic [REG_BITS-1:0]  ex_write_addr,
  input  logic [WORD_SIZE-1:0] ex_write_data,
  input  logic                 wb_write_enable,
  input  logic [REG_BITS-1:0]  wb_write_addr,
  input  logic [WORD_SIZE-1:0] wb_write_data,
  output logic [WORD_SIZE-1:0] data
);
  always_comb begin
    data = rf_data;
    if (ex_write_enable && !ex_is_load && ex_write_addr == read_addr)
      data = ex_write_data;
    else if (wb_write_enable && wb_write_addr == read_addr)
      data = wb_write_data;
  end
endmodule

// File: rtl/processor_operand_fetch.sv
// Operand-fetch stage of the asm18 core: decodes the fetched word, reads rx/ry
// with EX/WB forwarding, stalls on load-use hazards, drives the data-memory
// port for stores and calls, and parks in WAIT until a wake event.
// Ports:
//   clock, reset        clock; synchronous active-high reset
//   pipe (slave)        fetch-side and execute-side handshakes with payload
//   flush               kill incoming and registered instruction
//   wake_event          leave WAIT
//   reg_read_addr0/1    register-file read addresses; reg_read_data0/1 data
//   ex_*, wb_*          forwarding sources
//   memory_*            combinational data-memory write port
//   debug_state         current FSM state
// Handshake: a transfer happens on a clock edge where valid && ready. The stage
// raises out_valid one cycle after an accept and holds its payload stable while
// out_valid && !out_ready; in_ready never depends on in_valid.
module processor_operand_fetch
  import processor_pkg::*;
#(
  parameter int ADDR_SIZE = 18,
  parameter int WORD_SIZE = 18,
  parameter int REG_BITS  = 3,
  parameter int IMM_BITS  = 8,
  parameter int SP_REG    = 7
) (
  input  logic                 clock,
  input  logic                 reset,
  processor_operand_fetch_if.slave pipe,
  input  logic                 flush,
  input  logic                 wake_event,
  output logic [REG_BITS-1:0]  reg_read_addr0,
  output logic [REG_BITS-1:0]  reg_read_addr1,
  input  logic [WORD_SIZE-1:0] reg_read_data0,
  input  logic [WORD_SIZE-1:0] reg_read_data1,
  input  logic                 ex_write_enable,
  input  logic                 ex_is_load,
  input  logic [REG_BITS-1:0]  ex_write_addr,
  input  logic [WORD_SIZE-1:0] ex_write_data,
  input  logic                 wb_write_enable,
  input  logic [REG_BITS-1:0]  wb_write_addr,
  input  logic [WORD_SIZE-1:0] wb_write_data,
  output logic [ADDR_SIZE-1:0] memory_addr,
  output logic [WORD_SIZE-1:0] memory_in,
  output logic                 memory_write_enable,
  output state_t               debug_state
);
  state_t state, state_next;

  logic [3:0]           opcode;
  logic [REG_BITS-1:0]  rx, ry;
  logic [IMM_BITS-1:0]  imm;
  logic [1:0]           uses;
  logic [WORD_SIZE-1:0] fwd0, fwd1, operand1;
  logic [ADDR_SIZE-1:0] imm_ext, data1_plus_imm;
  logic                 hazard, accept, take;

  assign opcode = pipe.code_word[WORD_SIZE-1 -: 4];
  assign rx     = pipe.code_word[WORD_SIZE-5 -: REG_BITS];
  assign ry     = pipe.code_word[WORD_SIZE-5-REG_BITS -: REG_BITS];
  assign imm    = pipe.code_word[IMM_BITS-1:0];
  assign uses   = source_use(opcode);

  assign reg_read_addr0 = rx;
  assign reg_read_addr1 = (opcode == OP_CALL_IMM14) ? REG_BITS'(SP_REG) : ry;

  operand_forward #(.REG_BITS(REG_BITS), .WORD_SIZE(WORD_SIZE)) u_forward0 (
    .read_addr(reg_read_addr0), .rf_data(reg_read_data0),
    .ex_write_enable(ex_write_enable), .ex_is_load(ex_is_load),
    .ex_write_addr(ex_write_addr), .ex_write_data(ex_write_data),
    .wb_write_enable(wb_write_enable), .wb_write_addr(wb_write_addr),
    .wb_write_data(wb_write_data), .data(fwd0)
  );

  operand_forward #(.REG_BITS(REG_BITS), .WORD_SIZE(WORD_SIZE)) u_forward1 (
    .read_addr(reg_read_addr1), .rf_data(reg_read_data1),
    .ex_write_enable(ex_write_enable), .ex_is_load(ex_is_load),
    .ex_write_addr(ex_write_addr), .ex_write_data(ex_write_data),
    .wb_write_enable(wb_write_enable), .wb_write_addr(wb_write_addr),
    .wb_write_data(wb_write_data), .data(fwd1)
  );

  // A load in EX has no data yet; any source the opcode actually reads that
  // matches it must wait one cycle for the value to reach WB.
  assign hazard = ex_write_enable && ex_is_load &&
                  ((uses[1] && ex_write_addr == reg_read_addr0) ||
                   (uses[0] && ex_write_addr == reg_read_addr1));

  assign pipe.in_ready = (state == RUN) && !hazard && (!pipe.out_valid || pipe.out_ready);
  assign accept = pipe.in_valid && pipe.in_ready;
  assign take   = accept && !flush;

  assign imm_ext        = {{(ADDR_SIZE-IMM_BITS){imm[IMM_BITS-1]}}, imm};
  assign data1_plus_imm = fwd1[ADDR_SIZE-1:0] + imm_ext;
  assign operand1       = (opcode == OP_IF) ? WORD_SIZE'(pipe.ip) : fwd1;

  always_comb begin
    memory_addr         = data1_plus_imm;
    memory_in           = fwd0;
    memory_write_enable = 1'b0;
    if (opcode == OP_CALL_IMM14) begin
      memory_addr = fwd1[ADDR_SIZE-1:0];
      memory_in   = WORD_SIZE'(pipe.ip_plus_one);
    end
    if (take && (opcode == OP_WRITE_TO_MEMORY || opcode == OP_CALL_IMM14))
      memory_write_enable = 1'b1;
  end

  always_ff @(posedge clock) begin
    if (reset) state <= RUN;
    else       state <= state_next;
  end

  // The WAIT instruction is accepted in RUN, so a wake in that same cycle is
  // not seen; flush also releases WAIT.
  always_comb begin
    state_next = state;
    case (state)
      RUN:     if (take && opcode == OP_WAIT) state_next = WAIT;
      WAIT:    if (flush || wake_event)       state_next = RUN;
      default: state_next = RUN;
    endcase
  end

  assign debug_state = state;

  always_ff @(posedge clock) begin
    if (reset) begin
      pipe.out_valid          <= 1'b0;
      pipe.alu_data0_out      <= '0;
      pipe.alu_data1_out      <= '0;
      pipe.code_word_out      <= '0;
      pipe.ip_out             <= '0;
      pipe.ip_plus_one_out    <= '0;
      pipe.data1_plus_imm_out <= '0;
    end else if (flush) begin
      pipe.out_valid <= 1'b0;
    end else if (take) begin
      pipe.out_valid          <= 1'b1;
      pipe.alu_data0_out      <= fwd0;
      pipe.alu_data1_out      <= operand1;
      pipe.code_word_out      <= pipe.code_word;
      pipe.ip_out             <= pipe.ip;
      pipe.ip_plus_one_out    <= pipe.ip_plus_one;
      pipe.data1_plus_imm_out <= data1_plus_imm;
    end else if (pipe.out_ready) begin
      pipe.out_valid <= 1'b0;
    end
  end
endmodule

// File: doc/processor_operand_fetch.md
# processor_operand_fetch

Second pipeline stage of the asm18 core, parametrised successor of the operand-read stage: it decodes the fetched word, reads two source registers, forwards in-flight results from the execute and writeback stages, and drives the data-memory port for stores and calls. Unlike the previous stage, it uses valid/ready handshakes in both directions, detects load-use hazards, supports a pipeline flush, and leaves WAIT on a wake event. It sits between the fetch stage and the ALU/execute stage.

## Interface
- ADDR_SIZE, 18, address width
- WORD_SIZE, 18, data/instruction word width (≥ 4 + 2·REG_BITS + IMM_BITS)
- REG_BITS, 3, register index width (2^REG_BITS registers)
- IMM_BITS, 8, signed short immediate width
- SP_REG, 7, stack-pointer register index used by CALL

- clock  in  1  clock
- reset  in  1  reset, synchronous, active-high
- in_valid / in_ready  in / out  1  handshake from fetch; accept = in_valid && in_ready
- ip, ip_plus_one  in  ADDR_SIZE  address of the instruction and address + 1
- code_word  in  WORD_SIZE  instruction: opcode [W-1:W-4], rx, ry, imm below
- flush  in  1  kill the current and registered instruction (taken branch)
- wake_event  in  1  leave WAIT
- reg_read_addr0/1  out  REG_BITS  register-file read addresses (rx, ry)
- reg_read_data0/1  in  WORD_SIZE  asynchronous register-file read data
- ex_write_enable, ex_is_load  in  1  execute stage will write a register; the value comes from a load
- ex_write_addr / ex_write_data  in  REG_BITS / WORD_SIZE  execute-stage result
- wb_write_enable / wb_write_addr / wb_write_data  in  1 / REG_BITS / WORD_SIZE  writeback port
- memory_addr / memory_in  out  ADDR_SIZE / WORD_SIZE  data-memory address and write data
- memory_write_enable  out  1  write strobe
- out_valid / out_ready  out / in  1  handshake to execute
- alu_data0_out, alu_data1_out, code_word_out  out  WORD_SIZE  registered operands and instruction
- ip_out, ip_plus_one_out, data1_plus_imm_out  out  ADDR_SIZE  registered addresses

## Operation
- States: RUN, WAIT. Reset → RUN.
- Forwarding for each operand: if EX is eligible (ex_write_enable && !ex_is_load && address matches), use EX data; otherwise, if WB matches, use WB data; otherwise use the register file. EX has priority over WB.
- Load-use hazard: ex_write_enable && ex_is_load && ex_write_addr equals a source actually used by the opcode. While the hazard holds, in_ready = 0.
- in_ready = (state==RUN) && !hazard && (!out_valid || out_ready).
- data1_plus_imm = forwarded ry + sign-extended imm, computed at ADDR_SIZE width; it wraps modulo 2^ADDR_SIZE.
- OP_IF: operand 1 is replaced with ip.
- Memory port is combinational and qualified by accept && !flush:
  - OP_WRITE_TO_MEMORY: addr = data1_plus_imm, data = forwarded rx (not the raw register-file value), we = 1.
  - OP_CALL_IMM14: reg_read_addr1 = SP_REG, addr = forwarded SP, data = ip_plus_one, we = 1.
  - All other opcodes: we = 0.
- OP_WAIT: when accepted, the instruction is passed on as a normal output and the state goes to WAIT. In WAIT, when wake_event is high, the state returns to RUN.
- Flush:
  - Clears out_valid next cycle; the incoming word is dropped; we is forced to 0.
  - In WAIT, flush returns the state to RUN.
  - Flush has priority over both accept and wake_event.
- Opcode constants (OP_*) live in the shared package.

## Timing
- Latency is 1 cycle: on an accept at edge N, out_valid = 1 and the payload is valid after edge N.
- Output registers hold while out_valid && !out_ready.
- Reset values: out_valid = 0, all payload outputs = 0, state = RUN. in_ready = 1 after reset unless a hazard is present.
- Reset mid-WAIT or mid-stall returns to RUN with out_valid = 0.
- A wake_event sampled in RUN, or in the same cycle the WAIT instruction is accepted, is ignored.
- Wake at edge N: in_ready can be high in cycle N+1.
- A load-use hazard inserts exactly one bubble (out_valid = 0 for one cycle) once EX advances.

## Structure
- Package processor_pkg holds:
  - OP_* opcode constants
  - the typedef for the RUN/WAIT state enum
  - the function for opcode→uses_rx/uses_ry
- Sub-module operand_forward: one instance per operand, implementing the EX/WB/register-file mux.

## Test plan
- Back-to-back ALU ops, r1 written by EX with 0x00005 while WB writes r1 = 0x00009 → alu_data0_out = 0x00005.
- Load to r2 in EX, next instruction reads r2 → in_ready = 0 for one cycle, one bubble, then the WB-forwarded value appears.
- Store with rx = r3 forwarded 0x1234, ry = r4 = 0x3FFFF, imm = 0x01 → memory_addr = 0x00000 (wrap), memory_in = 0x1234, we for 1 cycle.
- CALL with SP = 0x00100, ip_plus_one = 0x00051 → memory_addr = 0x00100, memory_in = 0x00051.
- WAIT accepted, wake_event at cycle +5 → in_ready low for cycles +1…+5, high at +6. Repeat with flush at +3 → RUN at +4.
- out_ready held low for 3 cycles with in_valid high → outputs stable, no memory write repeated, no word lost.
